// File: rtl/mux2_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mux2_rr_arbiter
// Brief    : Round-robin arbiter with dwell limit driving a 2:1 mux select,
//            plus a registered output word with a valid strobe.
// Revision : 1.0 - initial release
// ============================================================================
module mux2_rr_arbiter #(
    parameter int WIDTH = 8,
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Req_A,
    input  logic             Req_B,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic             Select,
    output logic             Gnt_A,
    output logic             Gnt_B,
    output logic [WIDTH-1:0] Y,
    output logic             Y_valid
);

    localparam logic [1:0]       c_IDLE  = 2'd0;
    localparam logic [1:0]       c_GNT_A = 2'd1;
    localparam logic [1:0]       c_GNT_B = 2'd2;
    localparam logic [CNT_W-1:0] c_DWELL = CNT_W'(DWELL);
    localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_sat;
    logic             r_last_b;
    logic             r_run;
    logic             r_select;
    logic             w_xfer;
    logic [WIDTH-1:0] r_y;
    logic             r_y_valid;

    assign w_xfer = ((r_state == c_GNT_A) && Req_A) ||
                    ((r_state == c_GNT_B) && Req_B);

    // Dwell count this transfer would produce, pinned at DWELL.
    assign w_cnt_sat = (r_cnt >= c_DWELL) ? c_DWELL : (r_cnt + c_ONE);

    // r_run arms on the first edge after release, so arbitration starts
    // one full clock after reset is lifted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_last_b <= 1'b1;
            r_run    <= 1'b0;
            r_select <= 1'b0;
        end else begin
            r_run   <= 1'b1;
            r_state <= w_next_state;
            if (w_next_state != r_state) begin
                r_cnt <= '0;
                if (w_next_state == c_GNT_A) begin
                    r_last_b <= 1'b0;
                end else if (w_next_state == c_GNT_B) begin
                    r_last_b <= 1'b1;
                end
            end else if (w_xfer) begin
                r_cnt <= w_cnt_sat;
            end
            if (w_next_state == c_GNT_B) begin
                r_select <= 1'b1;
            end else if (w_next_state == c_GNT_A) begin
                r_select <= 1'b0;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (r_run) begin
                    if (Req_A && Req_B) begin
                        w_next_state = r_last_b ? c_GNT_A : c_GNT_B;
                    end else if (Req_A) begin
                        w_next_state = c_GNT_A;
                    end else if (Req_B) begin
                        w_next_state = c_GNT_B;
                    end
                end
            end
            c_GNT_A: begin
                if (!Req_A) begin
                    w_next_state = Req_B ? c_GNT_B : c_IDLE;
                end else if (Req_B && (w_cnt_sat == c_DWELL)) begin
                    w_next_state = c_GNT_B;
                end
            end
            c_GNT_B: begin
                if (!Req_B) begin
                    w_next_state = Req_A ? c_GNT_A : c_IDLE;
                end else if (Req_A && (w_cnt_sat == c_DWELL)) begin
                    w_next_state = c_GNT_A;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    always_comb begin
        Gnt_A   = (r_state == c_GNT_A);
        Gnt_B   = (r_state == c_GNT_B);
        Select  = r_select;
        Y       = r_y;
        Y_valid = r_y_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y       <= '0;
            r_y_valid <= 1'b0;
        end else begin
            r_y_valid <= w_xfer;
            if (w_xfer) begin
                r_y <= (r_state == c_GNT_B) ? B_in : A_in;
            end
        end
    end

endmodule
`default_nettype wire
